i2c_rx_capture: RTL and testbench

- Receive stage directly downstream of the I2C master controller.
- While the controller's read-enable (READ_DATA window) is high, it oversamples the bus on i2c_core_clk, shifts SDA MSB-first on SCL rising edges and assembles bytes.
- Completed bytes are written into an internal first-word-fall-through RX FIFO that the APB register block pops.
- Also flags bus START/STOP conditions.

---
 rtl/i2c_rx_capture.sv | 113 +++++++++++
 tb/tb_i2c_rx_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_capture.sv
// i2c_rx_capture: oversampled I2C receive shifter feeding a first-word-fall-through RX FIFO,
// with START/STOP condition detection.
module i2c_rx_capture #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              i2c_core_clk,
   input  logic              rst_n,
   input  logic              rx_enable,
   input  logic              scl_in,
   input  logic              sda_in,
   input  logic              rd_en,
   input  logic              clear,
   output logic [7:0]        rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              byte_done,
   output logic              start_det,
   output logic              stop_det
);
   // [0] first sync flop, [1] synchronised value, [2] history
   logic [2:0]        scl_q, sda_q;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              done_q, done_d;
   logic              start_q, stop_q;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        mem [FIFO_DEPTH];
   logic              scl_rise, scl_high, start_c, stop_c, pop, wr_ok;

   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_high = scl_q[1] & scl_q[2];
   assign start_c  = scl_high & sda_q[2] & ~sda_q[1];
   assign stop_c   = scl_high & ~sda_q[2] & sda_q[1];

   assign empty     = (count_q == '0);
   assign full      = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign byte_done = done_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   assign rd_data   = empty ? 8'h00 : mem[rd_ptr_q];

   // The completed byte stays in shift_q for the push cycle: the next SCL rise is several cycles away.
   assign pop   = rd_en & ~empty;
   assign wr_ok = done_q & (~full | pop);

   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      if (start_c | stop_c) begin
         shift_d   = 8'h00;
         bit_cnt_d = 3'd0;
      end else if (clear | ~rx_enable) begin
         bit_cnt_d = 3'd0;
      end else if (scl_rise) begin
         shift_d   = {shift_q[6:0], sda_q[1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
         done_d    = (bit_cnt_q == 3'd7);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_ok);
      rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
      count_d  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
      ovf_d    = ovf_q | (done_q & full & ~pop);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge i2c_core_clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q     <= 3'b111;
         sda_q     <= 3'b111;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         scl_q     <= {scl_q[1:0], scl_in};
         sda_q     <= {sda_q[1:0], sda_in};
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         start_q   <= start_c;
         stop_q    <= stop_c;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge i2c_core_clk) begin
      if (wr_ok & ~clear) mem[wr_ptr_q] <= shift_q;
   end
endmodule

// File: tb/tb_i2c_rx_capture.sv
// tb_i2c_rx_capture: directed and randomized byte captures checked against a queue-based FIFO model.
module tb_i2c_rx_capture;
   logic       clk = 1'b0;
   logic       rst_n, rx_enable, scl_in, sda_in, rd_en, clear;
   logic [7:0] rd_data;
   logic       empty, full, overflow, byte_done, start_det, stop_det;
   logic [3:0] count;

   i2c_rx_capture #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
      .i2c_core_clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .scl_in(scl_in),
      .sda_in(sda_in), .rd_en(rd_en), .clear(clear), .rd_data(rd_data), .empty(empty),
      .full(full), .count(count), .overflow(overflow), .byte_done(byte_done),
      .start_det(start_det), .stop_det(stop_det)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0, fails = 0;
   int bd_cnt = 0, st_cnt = 0, sp_cnt = 0, wide = 0;
   logic bd_p = 0, st_p = 0, sp_p = 0;
   logic [7:0] q[$];
   logic ovf_m = 0;

   // Pulse counters and width watchdog for the three event outputs
   always @(negedge clk) begin
      if (byte_done) bd_cnt++;
      if (start_det) st_cnt++;
      if (stop_det) sp_cnt++;
      if ((byte_done && bd_p) || (start_det && st_p) || (stop_det && sp_p)) wide++;
      bd_p = byte_done; st_p = start_det; sp_p = stop_det;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fifo(input string tag);
      logic [7:0] head;
      head = (q.size() != 0) ? q[0] : 8'h00;
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == 8));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(head));
      chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
   endtask

   task automatic send_bit(input logic b);
      scl_in = 1'b0; cyc(3);
      sda_in = b;    cyc(3);
      scl_in = 1'b1; cyc(6);
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
   endtask

   task automatic model_byte(input logic [7:0] v);
      if (q.size() < 8) q.push_back(v);
      else ovf_m = 1'b1;
   endtask

   task automatic capture(input logic [7:0] v);
      send_bits(v, 8);
      if (rx_enable) model_byte(v);
   endtask

   task automatic pop(input string tag);
      chk({tag, ".head"}, 32'(rd_data), 32'((q.size() != 0) ? q[0] : 8'h00));
      rd_en = 1'b1; cyc(1); rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   // Sends the first 7 bits, raises SCL for bit 0 and returns at the negedge where byte_done is high
   task automatic send_until_done(input logic [7:0] v, output logic ok);
      send_bits(v, 7);
      scl_in = 1'b0; cyc(3);
      sda_in = v[0]; cyc(3);
      scl_in = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cyc(1);
         ok = byte_done;
      end
   endtask

   initial begin
      int bd0, sp0, st0;
      logic ok;
      logic [7:0] v;
      rst_n = 0; scl_in = 1; sda_in = 1; rx_enable = 0; rd_en = 0; clear = 0;
      cyc(3);
      chk_fifo("in_reset");
      rst_n = 1; cyc(3);
      chk_fifo("after_reset");
      chk("reset.no_pulses", 32'(bd_cnt + st_cnt + sp_cnt), 32'd0);

      rx_enable = 1;
      capture(8'hA5);
      cyc(2);
      chk("a5.byte_done_pulses", 32'(bd_cnt), 32'd1);
      chk_fifo("a5");
      pop("a5.pop"); cyc(1);
      chk_fifo("a5.popped");

      rx_enable = 0; bd0 = bd_cnt;
      capture(8'h5A);
      cyc(2);
      chk("rxoff.no_byte_done", 32'(bd_cnt), 32'(bd0));
      chk_fifo("rxoff");
      rx_enable = 1;
      capture(8'h5A);
      cyc(2);
      chk_fifo("5a");
      pop("5a.pop");

      for (int i = 0; i < 8; i++) capture(8'(i));
      cyc(2);
      chk_fifo("fill8");
      bd0 = bd_cnt;
      capture(8'hFF);
      cyc(2);
      chk("ovf.byte_done", 32'(bd_cnt), 32'(bd0 + 1));
      chk_fifo("ovf");
      for (int i = 0; i < 8; i++) pop("drain");
      cyc(1);
      chk_fifo("drained");
      clear = 1; cyc(1); clear = 0;
      q.delete(); ovf_m = 0; cyc(1);
      chk_fifo("cleared");

      bd0 = bd_cnt; sp0 = sp_cnt; st0 = st_cnt;
      send_bits(8'hB0, 4);
      scl_in = 0; cyc(3); sda_in = 0; cyc(3); scl_in = 1; cyc(6); sda_in = 1; cyc(6);
      chk("stop.pulse", 32'(sp_cnt), 32'(sp0 + 1));
      chk("stop.no_push", 32'(bd_cnt), 32'(bd0));
      chk_fifo("stop");
      sda_in = 0; cyc(6);
      chk("start.pulse", 32'(st_cnt), 32'(st0 + 1));
      capture(8'h3C);
      cyc(2);
      chk("3c.byte_done", 32'(bd_cnt), 32'(bd0 + 1));
      chk_fifo("3c");
      pop("3c.pop");

      for (int i = 0; i < 12; i++) begin
         capture(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) pop("rnd.pop");
         cyc(1);
         chk_fifo("rnd");
      end
      clear = 1; cyc(1); clear = 0;
      q.delete(); ovf_m = 0;

      for (int i = 0; i < 8; i++) capture(8'($urandom_range(0, 255)));
      cyc(1);
      chk_fifo("full_again");
      send_until_done(8'h99, ok);
      chk("pushpop.byte_done_seen", 32'(ok), 32'd1);
      chk("pushpop.head", 32'(rd_data), 32'(q[0]));
      rd_en = 1; cyc(1); rd_en = 0;
      void'(q.pop_front()); q.push_back(8'h99);
      cyc(1);
      chk_fifo("pushpop");
      for (int i = 0; i < 8; i++) pop("pushpop.drain");
      cyc(1);
      chk_fifo("pushpop.drained");

      capture(8'($urandom_range(0, 255)));
      capture(8'($urandom_range(0, 255)));
      send_until_done(8'h42, ok);
      chk("clearpush.byte_done_seen", 32'(ok), 32'd1);
      clear = 1; cyc(1); clear = 0;
      q.delete(); ovf_m = 0; cyc(1);
      chk_fifo("clearpush");

      bd0 = bd_cnt;
      send_bits(8'hF0, 4);
      rst_n = 0; cyc(2);
      chk_fifo("midbyte_reset");
      chk("midbyte_reset.no_push", 32'(bd_cnt), 32'(bd0));
      rst_n = 1; cyc(2);
      v = 8'($urandom_range(0, 255));
      capture(v);
      cyc(2);
      chk("post_reset.byte_done", 32'(bd_cnt), 32'(bd0 + 1));
      chk_fifo("post_reset");

      chk("pulse_width", 32'(wide), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
